mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register for the 16-bit, 8-register pipeline. Consumes the EX/MEM register outputs: control groups, ALU/FU result, store data and destination register. Performs data-memory load/store with a parameterised access latency, stalling upstream while busy. Registers the write-back bundle for the WB stage.

Parameters:
DMEM_AW, 6, word-address width; memory holds 2^DMEM_AW 16-bit words.
MEM_LAT, 1, cycles per data-memory access; legal range 1..15.

Ports:
clk_i  in  1  clock
rst_n  in  1  synchronous active-low reset
WB  in  2  write-back control: [1] RegWrite, [0] MemtoReg
MEM  in  2  memory control: [1] MemRead, [0] MemWrite
FU_result  in  16  byte address for loads/stores; ALU result otherwise
RT_data  in  16  store data
Write_dst  in  3  destination register
stall_o  out  1  upstream must hold EX/MEM contents while high
WB_o  out  2  registered WB control
Read_data_o  out  16  registered load data
FU_result_o  out  16  registered FU_result
Write_dst_o  out  3  registered Write_dst

Behaviour:
- Reset is rst_n, synchronous, active-low, on clock clk_i. WB_o, Read_data_o, FU_result_o, Write_dst_o all become 0. FSM goes to IDLE and the counter to 0. Memory array is not cleared.
- Word address is FU_result[DMEM_AW:1]. Bit 0 is ignored; upper bits are ignored, so addresses wrap modulo the depth.
- A request (req) is MEM[1] | MEM[0]. If both bits are set, the access is treated as a write only; Read_data_o = 0.
- FSM states: IDLE and BUSY.
- IDLE, no req: capture inputs into the MEM/WB register every cycle, with Read_data_o = 0. stall_o = 0. Zero latency.
- IDLE, req, MEM_LAT = 1: perform the access at this edge and capture the MEM/WB register.
  - Write: mem[addr] <= RT_data.
  - Read: Read_data_o <= mem[addr], the pre-write value.
  - stall_o = 0.
- IDLE, req, MEM_LAT > 1: stall_o = 1 combinationally. Go to BUSY with cnt <= MEM_LAT-2. MEM/WB captures a bubble: WB_o = 0, other outputs hold.
- BUSY, cnt != 0: stall_o = 1, cnt decrements, bubble into MEM/WB.
- BUSY, cnt == 0: stall_o = 0. The access is performed at this edge and MEM/WB captures the real result. Return to IDLE.
- Total occupancy is MEM_LAT cycles. Each instruction performs exactly one memory access.
- Inputs are sampled only in the completing cycle. Upstream guarantees they are stable while stall_o = 1.
- Reset during BUSY: the pending access is discarded, no memory write occurs, and the FSM returns to IDLE.
- Back-to-back requests: the next req is seen in IDLE the cycle after completion, with no extra idle cycle.
- stall_o depends only on state, cnt and MEM; there is no combinational path from FU_result or RT_data.

Optional Feature:
MEM_WB_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_o (1 bit), reset 0.
  - A req with FU_result[0] = 1 sets misalign_o sticky until reset.
  - A misaligned write is suppressed; the memory is unchanged.
  - A misaligned read returns 0.
  - The instruction still retires with normal latency. WB_o is forced to 0 so no register write occurs.
- Undefined: port absent; bit 0 is silently ignored.

Decomposition:
- Shared package holds:
  - control bit-index constants: WB_REGWRITE = 1, WB_MEMTOREG = 0, MEM_READ = 1, MEM_WRITE = 0;
  - data width 16;
  - register-address width 3;
  - FSM state enum {IDLE, BUSY}.
- One sub-module, dmem_sp: single-port synchronous RAM with 16-bit data, a write enable and registered read. mem_wb_stage owns the FSM, counter and MEM/WB register.

Test Plan:
- MEM_LAT = 1, ALU op: WB = 2'b10, FU_result = 16'h1234, Write_dst = 5 -> next cycle WB_o = 2'b10, FU_result_o = 16'h1234, Write_dst_o = 5, Read_data_o = 0, stall_o never 1.
- MEM_LAT = 1, store then load: store RT_data = 16'hBEEF @ 16'h0010, then load @ 16'h0010 with WB = 2'b11 -> Read_data_o = 16'hBEEF after the load edge.
- MEM_LAT = 4, load: stall_o high exactly 3 cycles with WB_o = 0 during them. On the 4th edge Read_data_o = stored value and WB_o = 2'b11.
- MEM_LAT = 4, reset asserted in the 2nd BUSY cycle of a store of 16'hAAAA @ 16'h0020 -> all outputs 0, stall_o = 0 next cycle, a later load @ 16'h0020 returns the old value.
- Address wrap (DMEM_AW = 6): store 16'h5555 @ 16'h0080, load @ 16'h0000 -> Read_data_o = 16'h5555.
- MEM_WB_MISALIGN_TRAP_EN defined: store @ 16'h0011 -> misalign_o = 1 and stays 1, WB_o = 0, memory word 8 unchanged.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory-access / MEM-WB stage: control bit indices,
// datapath widths and the access FSM state type.
package mem_wb_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_stage_dmem_sp.sv
// Single-port synchronous data RAM: one write port and a registered read that
// only updates on a read enable, so the last load value holds between loads.
module dmem_sp
  import mem_wb_stage_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB register and MEM_LAT-cycle access stall.
// Optional macro MEM_WB_MISALIGN_TRAP_EN adds a sticky misalign_o trap.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DMEM_AW = 6,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [1:0]        WB,
  input  logic [1:0]        MEM,
  input  logic [DATA_W-1:0] FU_result,
  input  logic [DATA_W-1:0] RT_data,
  input  logic [REG_AW-1:0] Write_dst,
`ifdef MEM_WB_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              stall_o,
  output logic [1:0]        WB_o,
  output logic [DATA_W-1:0] Read_data_o,
  output logic [DATA_W-1:0] FU_result_o,
  output logic [REG_AW-1:0] Write_dst_o
);

  localparam bit       MULTI      = (MEM_LAT > 1);
  localparam logic [3:0] LAT_RELOAD = MULTI ? 4'(MEM_LAT - 2) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                req, is_wr, is_rd, misal;
  logic                access, capture;
  logic                ram_we, ram_re;
  logic [DMEM_AW-1:0]  addr;
  logic [DATA_W-1:0]   ram_rdata;
  logic [1:0]          wb_q;
  logic [DATA_W-1:0]   fu_q;
  logic [REG_AW-1:0]   dst_q;
  logic                rd_sel_q;

  assign req   = MEM[MEM_READ] | MEM[MEM_WRITE];
  assign is_wr = MEM[MEM_WRITE];
  assign is_rd = MEM[MEM_READ] & ~MEM[MEM_WRITE];
  assign addr  = FU_result[DMEM_AW:1];

`ifdef MEM_WB_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misal = req & FU_result[0];

  always_ff @(posedge clk_i) begin
    if (!rst_n)                misalign_q <= 1'b0;
    else if (access && misal)  misalign_q <= 1'b1;
  end
  assign misalign_o = misalign_q;
`else
  assign misal = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req && MULTI) begin
        state_d = BUSY;
        cnt_d   = LAT_RELOAD;
      end
      BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // access marks the single edge where the memory operation really happens
  always_comb begin
    stall_o = 1'b0;
    access  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!req)        capture = 1'b1;
        else if (!MULTI) begin access = 1'b1; capture = 1'b1; end
        else             stall_o = 1'b1;
      end
      BUSY: begin
        if (cnt_q != 4'd0) stall_o = 1'b1;
        else begin access = 1'b1; capture = 1'b1; end
      end
      default: ;
    endcase
  end

  // rst_n gating guarantees a reset mid-access never lands a write
  assign ram_we = access & is_wr & ~misal & rst_n;
  assign ram_re = access & is_rd & ~misal & rst_n;

  dmem_sp #(.AW(DMEM_AW)) u_dmem (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (addr),
    .wdata_i(RT_data),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wb_q     <= 2'b00;
      fu_q     <= '0;
      dst_q    <= '0;
      rd_sel_q <= 1'b0;
    end else if (capture) begin
      wb_q     <= misal ? 2'b00 : WB;
      fu_q     <= FU_result;
      dst_q    <= Write_dst;
      rd_sel_q <= access & is_rd & ~misal;
    end else begin
      wb_q     <= 2'b00;
    end
  end

  assign WB_o        = wb_q;
  assign FU_result_o = fu_q;
  assign Write_dst_o = dst_q;
  assign Read_data_o = rd_sel_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: one instance with MEM_LAT=1 and one with MEM_LAT=4,
// checked every cycle against a transaction-level model (honours MEM_WB_MISALIGN_TRAP_EN).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic [1:0]  wb_i       [2];
  logic [1:0]  mem_i      [2];
  logic [15:0] fu_i       [2];
  logic [15:0] rt_i       [2];
  logic [2:0]  dst_i      [2];
  logic        stall_o    [2];
  logic [1:0]  wb_o       [2];
  logic [15:0] rd_o       [2];
  logic [15:0] fu_o       [2];
  logic [2:0]  dst_o      [2];
  logic        mis_o      [2];

  logic        exp_stall  [2];
  logic [1:0]  exp_wb     [2];
  logic [15:0] exp_rd     [2];
  logic [15:0] exp_fu     [2];
  logic [2:0]  exp_dst    [2];
  logic        exp_mis    [2];
  logic [15:0] mem_m      [2][64];

  int n_checks = 0;
  int n_fail   = 0;
  int stall_seen4 = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DMEM_AW(6), .MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_n(rst_n[0]), .WB(wb_i[0]), .MEM(mem_i[0]),
    .FU_result(fu_i[0]), .RT_data(rt_i[0]), .Write_dst(dst_i[0]),
`ifdef MEM_WB_MISALIGN_TRAP_EN
    .misalign_o(mis_o[0]),
`endif
    .stall_o(stall_o[0]), .WB_o(wb_o[0]), .Read_data_o(rd_o[0]),
    .FU_result_o(fu_o[0]), .Write_dst_o(dst_o[0])
  );

  mem_wb_stage #(.DMEM_AW(6), .MEM_LAT(4)) u_dut4 (
    .clk_i(clk), .rst_n(rst_n[1]), .WB(wb_i[1]), .MEM(mem_i[1]),
    .FU_result(fu_i[1]), .RT_data(rt_i[1]), .Write_dst(dst_i[1]),
`ifdef MEM_WB_MISALIGN_TRAP_EN
    .misalign_o(mis_o[1]),
`endif
    .stall_o(stall_o[1]), .WB_o(wb_o[1]), .Read_data_o(rd_o[1]),
    .FU_result_o(fu_o[1]), .Write_dst_o(dst_o[1])
  );

  task automatic check(input string name, input int s, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, s, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        check("stall_o",     s, 16'(stall_o[s]), 16'(exp_stall[s]));
        check("WB_o",        s, 16'(wb_o[s]),    16'(exp_wb[s]));
        check("Read_data_o", s, rd_o[s],         exp_rd[s]);
        check("FU_result_o", s, fu_o[s],         exp_fu[s]);
        check("Write_dst_o", s, 16'(dst_o[s]),   16'(exp_dst[s]));
`ifdef MEM_WB_MISALIGN_TRAP_EN
        check("misalign_o",  s, 16'(mis_o[s]),   16'(exp_mis[s]));
`endif
      end
      if (stall_o[1]) stall_seen4++;
    end
  end

  // Drives one instruction (called at posedge+1) and returns at posedge+1 after it retires.
  task automatic issue(input int s, input logic [1:0] wb, input logic [1:0] mem,
                       input logic [15:0] fu, input logic [15:0] rt, input logic [2:0] dst);
    int          lat;
    logic        req, mis;
    logic [5:0]  addr;
    logic [15:0] rd;
    lat  = (s == 0) ? 1 : 4;
    req  = (mem != 2'b00);
    addr = 6'((fu >> 1) % 64);
`ifdef MEM_WB_MISALIGN_TRAP_EN
    mis  = req && fu[0];
`else
    mis  = 1'b0;
`endif
    wb_i[s] = wb; mem_i[s] = mem; fu_i[s] = fu; rt_i[s] = rt; dst_i[s] = dst;
    if (req) begin
      for (int k = 0; k < lat - 1; k++) begin
        exp_stall[s] = 1'b1;
        @(posedge clk); #1;
        exp_wb[s] = 2'b00;
      end
    end
    exp_stall[s] = 1'b0;
    rd = 16'h0000;
    if (mem == 2'b10 && !mis) rd = mem_m[s][addr];
    if (mem[0] && !mis)       mem_m[s][addr] = rt;
    @(posedge clk); #1;
    exp_wb[s]  = mis ? 2'b00 : wb;
    exp_rd[s]  = rd;
    exp_fu[s]  = fu;
    exp_dst[s] = dst;
    if (mis) exp_mis[s] = 1'b1;
  endtask

  initial begin
    int base;
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; wb_i[s] = 0; mem_i[s] = 0; fu_i[s] = 0; rt_i[s] = 0; dst_i[s] = 0;
      exp_stall[s] = 0; exp_wb[s] = 0; exp_rd[s] = 0; exp_fu[s] = 0; exp_dst[s] = 0; exp_mis[s] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset WB_o", 1, 16'(wb_o[1]), 16'h0);
    check("reset FU_result_o", 0, fu_o[0], 16'h0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    chk_en = 1'b1;

    // single-cycle instance: ALU op, store/load, address wrap, write-only on both bits
    issue(0, 2'b10, 2'b00, 16'h1234, 16'h0000, 3'd5);
    check("alu FU_result_o", 0, fu_o[0], 16'h1234);
    check("alu Write_dst_o", 0, 16'(dst_o[0]), 16'h5);
    issue(0, 2'b00, 2'b01, 16'h0010, 16'hBEEF, 3'd0);
    issue(0, 2'b11, 2'b10, 16'h0010, 16'h0000, 3'd3);
    check("load BEEF", 0, rd_o[0], 16'hBEEF);
    issue(0, 2'b00, 2'b01, 16'h0080, 16'h5555, 3'd0);
    issue(0, 2'b11, 2'b10, 16'h0000, 16'h0000, 3'd2);
    check("wrap load", 0, rd_o[0], 16'h5555);
    issue(0, 2'b10, 2'b11, 16'h0010, 16'h1357, 3'd1);
    check("rw as write Read_data_o", 0, rd_o[0], 16'h0000);
    issue(0, 2'b11, 2'b10, 16'h0010, 16'h0000, 3'd4);
    check("after rw load", 0, rd_o[0], 16'h1357);
    issue(0, 2'b10, 2'b00, 16'hABCD, 16'h0000, 3'd7);

    // four-cycle instance: stores, stalled load, reset mid-store, back-to-back loads
    issue(1, 2'b00, 2'b01, 16'h0010, 16'hCAFE, 3'd0);
    issue(1, 2'b00, 2'b01, 16'h0020, 16'h1111, 3'd0);
    base = stall_seen4;
    issue(1, 2'b11, 2'b10, 16'h0010, 16'h0000, 3'd6);
    check("lat4 stall cycles", 1, 16'(stall_seen4 - base), 16'd3);
    check("lat4 load", 1, rd_o[1], 16'hCAFE);
    check("lat4 WB_o", 1, 16'(wb_o[1]), 16'h3);

    wb_i[1] = 2'b00; mem_i[1] = 2'b01; fu_i[1] = 16'h0020; rt_i[1] = 16'hAAAA; dst_i[1] = 3'd0;
    exp_stall[1] = 1'b1;
    @(posedge clk); #1; exp_wb[1] = 2'b00;
    @(posedge clk); #1; exp_wb[1] = 2'b00;
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    mem_i[1] = 2'b00; fu_i[1] = 16'h0000; rt_i[1] = 16'h0000;
    exp_stall[1] = 0; exp_wb[1] = 0; exp_rd[1] = 0; exp_fu[1] = 0; exp_dst[1] = 0; exp_mis[1] = 0;
    check("post-reset FU_result_o", 1, fu_o[1], 16'h0);
    issue(1, 2'b11, 2'b10, 16'h0020, 16'h0000, 3'd2);
    check("reset discarded store", 1, rd_o[1], 16'h1111);
    issue(1, 2'b11, 2'b10, 16'h0010, 16'h0000, 3'd3);
    check("back-to-back load", 1, rd_o[1], 16'hCAFE);
    issue(1, 2'b00, 2'b00, 16'h0042, 16'h0000, 3'd1);

`ifdef MEM_WB_MISALIGN_TRAP_EN
    issue(0, 2'b00, 2'b01, 16'h0010, 16'h7777, 3'd0);
    issue(0, 2'b10, 2'b01, 16'h0011, 16'h9999, 3'd2);
    check("misalign set", 0, 16'(mis_o[0]), 16'h1);
    check("misalign WB_o", 0, 16'(wb_o[0]), 16'h0);
    issue(0, 2'b11, 2'b10, 16'h0010, 16'h0000, 3'd3);
    check("misaligned store suppressed", 0, rd_o[0], 16'h7777);
    issue(0, 2'b11, 2'b10, 16'h0011, 16'h0000, 3'd3);
    check("misaligned load zero", 0, rd_o[0], 16'h0000);
    issue(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 3'd0);
    check("misalign sticky", 0, 16'(mis_o[0]), 16'h1);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
